clkdiv_ratio_ctrl: RTL and testbench
====================================

Name: clkdiv_ratio_ctrl

Overview:
- Sequences run-time division-ratio changes for the team's programmable clock divider (ClkDiv), so the divided clock never sees a ratio change while it is running.
- Accepts ratio-change requests over a valid/ready handshake and drives the divider's clock-enable and ratio inputs.
- Each change runs in order: gate the divider, load the new ratio, re-enable, wait one full divided period, report completion.
- Sits beside the divider in the clock/reset subsystem; requests come from the system controller or register file.

Parameters:
- DIV_BITS, 8, width of ratio path; matches divider div_bits.
- DEF_RATIO, 2, ratio driven out of reset.
- GATE_CYCLES, 4, ref-clock cycles the divider is held disabled before a new ratio is loaded; legal range 1..255.

Ports:
- i_ref_clk  in  1  reference clock; same clock as the divider.
- i_rst_n  in  1  reset.
- i_run  in  1  master enable; the divider may run only while high.
- i_req_valid  in  1  ratio-change request valid.
- i_req_ratio  in  DIV_BITS  requested ratio.
- o_req_ready  out  1  request accepted on an edge where valid && ready.
- o_div_en  out  1  drives divider i_clk_en.
- o_div_ratio  out  DIV_BITS  drives divider i_div_ratio.
- o_busy  out  1  high while a change sequence is in progress.
- o_done  out  1  one-cycle pulse when a change completes.
- o_err  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset and clock: i_rst_n is asynchronous, active-low; i_ref_clk is the clock. All outputs are registered.
- Reset values:
  - state IDLE
  - o_div_ratio = DEF_RATIO
  - o_div_en = 0, o_busy = 0, o_done = 0, o_err = 0
  - o_req_ready = 1 once reset deasserts
- Handshake:
  - o_req_ready = (state == IDLE).
  - Accept occurs on an edge with i_req_valid && o_req_ready.
  - Requesters hold valid/ratio stable until accepted.
  - While busy, requests stall; none are dropped or queued.
- IDLE:
  - o_div_en <= i_run.
  - On accept with ratio == 0: o_err = 1 next cycle; ratio and state unchanged.
  - On accept with ratio == o_div_ratio: o_done = 1 next cycle; no gating (fast path).
  - On accept with any other ratio: latch the ratio; go to GATE.
- GATE:
  - o_div_en <= 0; o_busy = 1.
  - Counter runs GATE_CYCLES cycles, then go to LOAD.
  - o_div_ratio <= latched ratio on the GATE->LOAD edge, while o_div_en is still 0.
- LOAD:
  - One cycle; o_div_en stays 0.
  - Next state SETTLE; o_div_en <= i_run on that edge.
- SETTLE:
  - Lasts exactly new-ratio cycles (ratio 1 = 1 cycle), counted by a DIV_BITS-wide counter that saturates and never wraps.
  - o_div_en follows i_run.
  - Then go to IDLE with o_done = 1 for one cycle; o_busy drops the same edge.
- Timing (accept at edge N):
  - o_div_en = 0 from N+1.
  - o_div_ratio changes at N+GATE_CYCLES.
  - o_div_en re-asserts at N+GATE_CYCLES+1.
  - o_done is high in the cycle after edge N+GATE_CYCLES+1+ratio.
- i_run low in any state forces o_div_en = 0 next edge; the sequence continues and timing is unaffected.
- o_done and o_err are never high in the same cycle; each is a pulse that is never held.
- A new request may be accepted in the same cycle o_done is high (state is IDLE).
- Reset mid-sequence: return to reset values immediately; the in-flight ratio is discarded; o_div_ratio = DEF_RATIO.
- Ratio 1 is legal (the divider passes the ref clock through).

Test Plan:
- Reset, i_run = 1 -> o_div_ratio = 2, o_div_en = 1 one edge after reset release, o_req_ready = 1, o_busy = 0.
- GATE_CYCLES = 4, accept ratio 6 at edge N -> o_div_en 0 from N+1; o_div_ratio = 6 at N+4; o_div_en = 1 at N+5; o_done pulse after edge N+11; divider output period = 6 ref clocks afterwards.
- Request ratio 0 -> o_err single pulse, o_div_ratio and o_div_en unchanged, o_busy never set.
- Request ratio equal to current (2) -> o_done pulse next cycle, o_div_en never drops.
- Second request held valid during busy -> o_req_ready low until the o_done cycle, accepted then, executed fully.
- Reset asserted in SETTLE of ratio 6 change -> all outputs return to reset values asynchronously; after release o_div_ratio = 2, no o_done.

Source files
------------

// File: rtl/clkdiv_ratio_ctrl_if.sv
// Ratio-change request channel between a requester and clkdiv_ratio_ctrl.
// Valid/ratio are held by the master until an edge where valid && ready.
`timescale 1ns/1ps
interface clkdiv_ratio_ctrl_if #(
    parameter int unsigned DIV_BITS = 8
);
    logic                req_valid;
    logic [DIV_BITS-1:0] req_ratio;
    logic                req_ready;

    modport master (
        output req_valid,
        output req_ratio,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_ratio,
        output req_ready
    );
endinterface

// File: rtl/clkdiv_ratio_ctrl.sv
// Sequences run-time ratio changes for the clock divider: gate, load, re-enable,
// settle for one divided period, then report completion.
`timescale 1ns/1ps
module clkdiv_ratio_ctrl #(
    parameter int unsigned DIV_BITS    = 8,
    parameter int unsigned DEF_RATIO   = 2,
    parameter int unsigned GATE_CYCLES = 4
) (
    input  logic                i_ref_clk,
    input  logic                i_rst_n,
    input  logic                i_run,
    clkdiv_ratio_ctrl_if.slave  req,
    output logic                o_div_en,
    output logic [DIV_BITS-1:0] o_div_ratio,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err
);

    // One counter serves both the gate phase (up to 255) and the settle phase.
    localparam int unsigned CntW = (DIV_BITS > 8) ? DIV_BITS : 8;

    typedef enum logic [1:0] {StIdle, StGate, StLoad, StSettle} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [DIV_BITS-1:0] pend_q, pend_d;
    logic [DIV_BITS-1:0] ratio_q, ratio_d;
    logic                en_q, en_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                ready_q, ready_d;
    logic                accept;

    assign accept = req.req_valid && ready_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        ratio_d = ratio_q;
        en_d    = i_run;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (req.req_ratio == '0) begin
                        err_d = 1'b1;
                    end else if (req.req_ratio == ratio_q) begin
                        done_d = 1'b1;
                    end else begin
                        pend_d  = req.req_ratio;
                        cnt_d   = '0;
                        state_d = StGate;
                    end
                end
            end
            StGate: begin
                en_d = 1'b0;
                if (cnt_q == CntW'(GATE_CYCLES - 1)) begin
                    // Ratio switches while the divider is still gated off.
                    ratio_d = pend_q;
                    state_d = StLoad;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StLoad: begin
                cnt_d   = CntW'(1);
                state_d = StSettle;
            end
            StSettle: begin
                if (cnt_q >= CntW'(ratio_q)) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d  = (state_d != StIdle);
        ready_d = (state_d == StIdle);
    end

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pend_q  <= DIV_BITS'(DEF_RATIO);
            ratio_q <= DIV_BITS'(DEF_RATIO);
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ratio_q <= ratio_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    assign req.req_ready = ready_q;
    assign o_div_en      = en_q;
    assign o_div_ratio   = ratio_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_err         = err_q;

endmodule

// File: tb/tb_clkdiv_ratio_ctrl.sv
// Directed bench for clkdiv_ratio_ctrl with hand-computed expectations
// (DIV_BITS=8, DEF_RATIO=2, GATE_CYCLES=4).
`timescale 1ns/1ps
module tb_clkdiv_ratio_ctrl;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic       div_en;
    logic [7:0] div_ratio;
    logic       busy;
    logic       done;
    logic       err;

    int total;
    int bad;

    clkdiv_ratio_ctrl_if #(.DIV_BITS(8)) req_if ();

    clkdiv_ratio_ctrl #(
        .DIV_BITS   (8),
        .DEF_RATIO  (2),
        .GATE_CYCLES(4)
    ) dut (
        .i_ref_clk  (clk),
        .i_rst_n    (rst_n),
        .i_run      (run),
        .req        (req_if.slave),
        .o_div_en   (div_en),
        .o_div_ratio(div_ratio),
        .o_busy     (busy),
        .o_done     (done),
        .o_err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one ref-clock edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until o_done, bounded; checks the number of edges taken.
    task automatic wait_done(input string tag, input int exp_edges);
        int n;
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        check(tag, n, exp_edges);
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        rst_n            = 1'b0;
        run              = 1'b1;
        req_if.req_valid = 1'b0;
        req_if.req_ratio = 8'd0;

        tick();
        tick();
        check("rst_ratio", div_ratio, 8'd2);
        check("rst_en", div_en, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        rst_n = 1'b1;
        tick();
        check("post_rst_en", div_en, 1'b1);
        check("post_rst_ready", req_if.req_ready, 1'b1);
        check("post_rst_busy", busy, 1'b0);

        // Run low in idle gates the divider on the next edge.
        run = 1'b0;
        tick();
        check("run_low_en", div_en, 1'b0);
        run = 1'b1;
        tick();
        check("run_high_en", div_en, 1'b1);

        // Ratio 0 is rejected.
        req_if.req_valid = 1'b1;
        req_if.req_ratio = 8'd0;
        tick();
        req_if.req_valid = 1'b0;
        check("zero_err", err, 1'b1);
        check("zero_done", done, 1'b0);
        check("zero_busy", busy, 1'b0);
        check("zero_ratio", div_ratio, 8'd2);
        check("zero_en", div_en, 1'b1);
        tick();
        check("zero_err_pulse", err, 1'b0);
        check("zero_busy2", busy, 1'b0);

        // Same ratio takes the fast path.
        req_if.req_valid = 1'b1;
        req_if.req_ratio = 8'd2;
        tick();
        req_if.req_valid = 1'b0;
        check("same_done", done, 1'b1);
        check("same_err", err, 1'b0);
        check("same_en", div_en, 1'b1);
        check("same_busy", busy, 1'b0);
        tick();
        check("same_done_pulse", done, 1'b0);
        check("same_en2", div_en, 1'b1);

        // Ratio 6: accept at edge N, walk edges N+1..N+11.
        req_if.req_valid = 1'b1;
        req_if.req_ratio = 8'd6;
        tick();
        req_if.req_valid = 1'b0;
        check("r6_busy_n", busy, 1'b1);
        check("r6_ready_n", req_if.req_ready, 1'b0);
        for (int k = 1; k <= 11; k++) begin
            tick();
            check($sformatf("r6_en_%0d", k), div_en, (k >= 5) ? 1 : 0);
            check($sformatf("r6_ratio_%0d", k), div_ratio, (k >= 4) ? 6 : 2);
            check($sformatf("r6_done_%0d", k), done, (k == 11) ? 1 : 0);
            check($sformatf("r6_busy_%0d", k), busy, (k < 11) ? 1 : 0);
        end
        check("r6_ready_end", req_if.req_ready, 1'b1);
        tick();
        check("r6_done_pulse", done, 1'b0);

        // Ratio 3 then a second request (5) held valid through the busy window.
        req_if.req_valid = 1'b1;
        req_if.req_ratio = 8'd3;
        tick();
        req_if.req_ratio = 8'd5;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("stall_ready_%0d", k), req_if.req_ready, (k == 8) ? 1 : 0);
            check($sformatf("stall_done_%0d", k), done, (k == 8) ? 1 : 0);
        end
        check("r3_ratio", div_ratio, 8'd3);
        tick();
        req_if.req_valid = 1'b0;
        check("r5_accept_busy", busy, 1'b1);
        check("r5_accept_done", done, 1'b0);
        wait_done("r5_latency", 10);
        check("r5_ratio", div_ratio, 8'd5);
        check("r5_en", div_en, 1'b1);
        tick();

        // Run low mid-sequence: enable drops, timing unchanged.
        req_if.req_valid = 1'b1;
        req_if.req_ratio = 8'd1;
        tick();
        req_if.req_valid = 1'b0;
        for (int k = 1; k <= 5; k++) tick();
        check("r1_en_reasserted", div_en, 1'b1);
        run = 1'b0;
        tick();
        check("r1_run_low_en", div_en, 1'b0);
        check("r1_done", done, 1'b1);
        check("r1_ratio", div_ratio, 8'd1);
        run = 1'b1;
        tick();

        // Reset during SETTLE of a ratio-6 change.
        req_if.req_valid = 1'b1;
        req_if.req_ratio = 8'd6;
        tick();
        req_if.req_valid = 1'b0;
        for (int k = 1; k <= 6; k++) tick();
        check("pre_rst_ratio", div_ratio, 8'd6);
        check("pre_rst_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_rst_ratio", div_ratio, 8'd2);
        check("async_rst_en", div_en, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_done", done, 1'b0);
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("after_rst_done_%0d", k), done, 1'b0);
        end
        check("after_rst_ratio", div_ratio, 8'd2);
        check("after_rst_en", div_en, 1'b1);
        check("after_rst_busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
